// File: rtl/cpu_pkg.sv
// Constants shared across the CPU front end: default datapath width, reset
// vector, and the instruction word presented when no fetched word is available.
package cpu_pkg;

    localparam int          WIDTH_DEFAULT    = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INS          = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: request/response channel to instruction memory, redirect
// input from execute, and the {pc, ins} channel toward decode.
interface fetch_unit_if #(
    parameter int WIDTH = cpu_pkg::WIDTH_DEFAULT
);

    logic             imem_req_valid;
    logic [WIDTH-1:0] imem_req_addr;
    logic             imem_req_ready;
    logic             imem_rsp_valid;
    logic [WIDTH-1:0] imem_rsp_data;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             ins_valid;
    logic             ins_ready;
    logic [WIDTH-1:0] ins;
    logic [WIDTH-1:0] pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect, redirect_pc,
        output ins_valid, ins, pc,
        input  ins_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect, redirect_pc,
        input  ins_valid, ins, pc,
        output ins_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, ins} pairs with flush. The head is read
// combinationally so a word written in one cycle is visible the next.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           push_pc,
    input  logic [WIDTH-1:0]           push_ins,
    output logic [WIDTH-1:0]           head_pc,
    output logic [WIDTH-1:0]           head_ins,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] pc_mem  [DEPTH];
    logic [WIDTH-1:0] ins_mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;

    // The owner never pushes when full nor pops when empty, so no guards here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr_reg]  <= push_pc;
            ins_mem[wr_ptr_reg] <= push_ins;
        end
    end

    assign head_pc  = pc_mem[rd_ptr_reg];
    assign head_ins = ins_mem[rd_ptr_reg];
    assign count    = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential address generation under a credit limit,
// in-order response buffering, and redirect flush of buffered and in-flight words.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEFAULT,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    localparam int               CW   = $clog2(DEPTH+1);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(4);

    logic [WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
    logic [WIDTH-1:0] rsp_pc_reg, rsp_pc_next;
    logic [CW-1:0]    live_reg, live_next;
    logic [CW-1:0]    stale_reg, stale_next;
    logic [CW-1:0]    count;
    logic [CW+1:0]    credit_used;
    logic [WIDTH-1:0] head_pc, head_ins, target_pc;
    logic             req_fire, rsp_ok, rsp_drop, rsp_keep, pop;

    assign target_pc   = bus.redirect_pc & ~WIDTH'(3);
    assign credit_used = (CW+2)'(count) + (CW+2)'(live_reg) + (CW+2)'(stale_reg);

    // Every slot in the buffer is pre-reserved at issue time, so it can never overflow.
    assign bus.imem_req_valid = rst_n && !bus.redirect && (credit_used < (CW+2)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc_reg;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_ok   = bus.imem_rsp_valid && ((live_reg != '0) || (stale_reg != '0));
    assign rsp_drop = rsp_ok && (stale_reg != '0);
    assign rsp_keep = rsp_ok && (stale_reg == '0) && !bus.redirect;

    assign bus.ins_valid = (count != '0);
    assign pop           = bus.ins_valid && bus.ins_ready && !bus.redirect;
    assign bus.ins       = bus.ins_valid ? head_ins : WIDTH'(NOP_INS);
    assign bus.pc        = bus.ins_valid ? head_pc  : '0;

    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        rsp_pc_next   = rsp_pc_reg;
        live_next     = live_reg;
        stale_next    = stale_reg;
        if (bus.redirect) begin
            fetch_pc_next = target_pc;
            rsp_pc_next   = target_pc;
            live_next     = '0;
            // A word arriving now retires from whichever counter owned it.
            stale_next    = stale_reg + live_reg - CW'(rsp_ok);
        end else begin
            if (req_fire) fetch_pc_next = fetch_pc_reg + STEP;
            if (rsp_keep) rsp_pc_next   = rsp_pc_reg + STEP;
            live_next  = live_reg + CW'(req_fire) - CW'(rsp_keep);
            stale_next = stale_reg - CW'(rsp_drop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg <= RESET_PC;
            rsp_pc_reg   <= RESET_PC;
            live_reg     <= '0;
            stale_reg    <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            rsp_pc_reg   <= rsp_pc_next;
            live_reg     <= live_next;
            stale_reg    <= stale_next;
        end
    end

    fetch_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rsp_keep),
        .pop      (pop),
        .flush    (bus.redirect),
        .push_pc  (rsp_pc_reg),
        .push_ins (bus.imem_rsp_data),
        .head_pc  (head_pc),
        .head_ins (head_ins),
        .count    (count)
    );

endmodule
